if_fetch: RTL
=============

Name: if_fetch

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the PC and runs a req/ack handshake with the instruction bus.
- Drives if_pc/if_inst for the IF/ID register each cycle, and holds a one-entry skid buffer so an instruction returned while IF/ID is stalled is not lost.
- Raises stallreq toward the pipeline controller while a fetch is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- stall  in  6  controller stall vector; only stall[1] (IF/ID hold) and stall[2] (ID hold) are used.
- flush  in  1  exception flush; redirect to new_pc.
- new_pc  in  32  exception handler / eret target.
- branch_flag_i  in  1  taken branch resolved in ID.
- branch_target_address_i  in  32  branch target.
- ibus_req_o  out  1  fetch request.
- ibus_addr_o  out  32  fetch address.
- ibus_ack_i  in  1  data valid; may be high in the same cycle as req (zero-wait).
- ibus_rdata_i  in  32  instruction word.
- if_pc  out  32  PC to IF/ID.
- if_inst  out  32  instruction to IF/ID; 32'h0 (NOP) when not valid.
- if_valid  out  1  if_pc/if_inst carry a real fetch this cycle.
- stallreq_o  out  1  request pipeline stall.
- inst_adel_o  out  1  fetch address error (see Optional Feature).

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, pc=RESET_PC, br_pend=0, buf=0. All outputs 0 except if_pc=RESET_PC.
- States: IDLE, REQ, HOLD, DRAIN.
- IDLE: ibus_req_o=0. Unconditionally goes to REQ on the next edge, so the first request issues 1 cycle after rst deasserts.
- REQ:
  - ibus_req_o=1, ibus_addr_o=pc; address stays stable until an ack is sampled.
  - if_pc=pc; if_inst=ibus_rdata_i and if_valid=1 when ack=1, otherwise 0/0.
  - On ack with flush=1: discard data, pc<=new_pc, br_pend<=0, stay in REQ.
  - On ack with stall[1]=0: pc<=next_pc, stay in REQ. Sustains 1 instruction/cycle with zero-wait ack.
  - On ack with stall[1]=1: buf<=rdata, bufpc<=pc, go to HOLD.
  - No ack with flush=1: go to DRAIN, pend_pc<=new_pc, br_pend<=0.
- HOLD:
  - ibus_req_o=0; if_pc=bufpc, if_inst=buf, if_valid=1.
  - stall[1]=0: pc<=next_pc, go to REQ (request issues in that same next cycle).
  - flush=1: pc<=new_pc, go to REQ; buffer dropped.
- DRAIN:
  - The bus cannot be abandoned, so ibus_req_o=1 is held at the old address; if_valid=0.
  - On ack: discard data, pc<=pend_pc, go to REQ.
  - A further flush in DRAIN overwrites pend_pc.
- next_pc: br_pend ? br_target : pc+4, with 32-bit wrap (32'hFFFF_FFFC+4 = 0). Taking the branch clears br_pend.
- Branch latch:
  - When branch_flag_i=1 and stall[2]=0 (branch leaving ID), set br_pend=1 and capture br_target.
  - The fetch completing at or after that point is the delay slot. The target is applied to the fetch after the delay slot.
  - If branch and ack coincide in REQ, that ack completes the delay-slot fetch and is itself presented normally. br_pend is set that same edge, so the following fetch goes to the target.
- Priority: rst > flush > ack > branch latch. Flush clears any pending branch.
- stallreq_o (combinational) = (REQ & ~ibus_ack_i) | DRAIN.
- ibus_ack_i while ibus_req_o=0 is ignored.

Optional Feature:
- Macro: IF_ALIGN_CHECK_EN.
- Defined:
  - In REQ with pc[1:0]≠0, no request is issued.
  - if_inst=0, if_valid=1, inst_adel_o=1 for that cycle.
  - The block then parks in HOLD with inst_adel_o held at 1 until flush. Misalignment does not stall (stallreq_o=0).
- Not defined: the address goes to the bus unchanged and inst_adel_o is tied to 0.

Test Plan:
- Reset/zero-wait: rst low→high with ack tied to req → ibus_addr_o 0,4,8,C on consecutive cycles; if_valid=1 each cycle; stallreq_o=0.
- Wait states: ack delayed 2 cycles at pc=0x10 → stallreq_o=1 for 2 cycles; if_valid=0 then 1 with if_inst=rdata; next addr 0x14.
- Skid buffer: ack at pc=0x20 (rdata=0x24020005) with stall[1]=1 for 3 cycles → HOLD holds if_inst=0x24020005 and if_pc=0x20, no request; stall release → next request 0x24.
- Branch with delay slot: branch_flag_i=1, target 0x100, stall[2]=0 during the fetch of 0x44 (ack that cycle) → fetch 0x48 is not issued; sequence is 0x44, then 0x100.
- Flush during wait: at pc=0x30 with no ack, flush with new_pc=0x180 → DRAIN keeps addr 0x30 until ack; data discarded; next addr 0x180; pending branch cleared.
- Async reset mid-fetch plus IF_ALIGN_CHECK_EN: rst low in REQ → ibus_req_o=0 immediately. Separately, flush to 0x182 → no request; inst_adel_o=1 and held until the next flush.

Source files
------------

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage feeding IF/ID; owns the PC, drives the ibus req/ack handshake
// and keeps a one-entry skid buffer. Define IF_ALIGN_CHECK_EN to trap misaligned fetch addresses.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid,
  output logic        stallreq_o,
  output logic        inst_adel_o
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StDrain} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic        r_br_pend;
  logic [31:0] r_br_target;
  logic [31:0] r_buf;
  logic [31:0] r_bufpc;
  logic [31:0] r_pend_pc;
  logic        r_adel;

  logic        w_br_take;
  logic [31:0] w_next_pc;
  logic        w_misalign;
  logic        w_unused_stall;

  assign w_unused_stall = ^{stall[5:3], stall[0]};

  // A branch leaving ID in the same cycle as the delay-slot fetch completes redirects immediately.
  assign w_br_take = branch_flag_i & ~stall[2];
  assign w_next_pc = w_br_take ? branch_target_address_i :
                     r_br_pend ? r_br_target : (r_pc + 32'd4);

`ifdef IF_ALIGN_CHECK_EN
  assign w_misalign = (r_state == StReq) && (r_pc[1:0] != 2'b00);
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StIdle;
      r_pc        <= RESET_PC;
      r_br_pend   <= 1'b0;
      r_br_target <= 32'h0;
      r_buf       <= 32'h0;
      r_bufpc     <= 32'h0;
      r_pend_pc   <= 32'h0;
      r_adel      <= 1'b0;
    end else begin
      // Latch by default; later assignments below take priority (flush / consumed branch).
      if (w_br_take) begin
        r_br_pend   <= 1'b1;
        r_br_target <= branch_target_address_i;
      end
      unique case (r_state)
        StIdle: begin
          if (flush) begin
            r_pc      <= new_pc;
            r_br_pend <= 1'b0;
          end
          r_state <= StReq;
        end
        StReq: begin
          if (w_misalign) begin
            if (flush) begin
              r_pc      <= new_pc;
              r_br_pend <= 1'b0;
            end else begin
              r_buf   <= 32'h0;
              r_bufpc <= r_pc;
              r_adel  <= 1'b1;
              r_state <= StHold;
            end
          end else if (ibus_ack_i) begin
            if (flush) begin
              r_pc      <= new_pc;
              r_br_pend <= 1'b0;
            end else if (!stall[1]) begin
              r_pc      <= w_next_pc;
              r_br_pend <= 1'b0;
            end else begin
              r_buf   <= ibus_rdata_i;
              r_bufpc <= r_pc;
              r_state <= StHold;
            end
          end else if (flush) begin
            r_pend_pc <= new_pc;
            r_br_pend <= 1'b0;
            r_state   <= StDrain;
          end
        end
        StHold: begin
          if (flush) begin
            r_pc      <= new_pc;
            r_br_pend <= 1'b0;
            r_adel    <= 1'b0;
            r_state   <= StReq;
          end else if (!stall[1] && !r_adel) begin
            r_pc      <= w_next_pc;
            r_br_pend <= 1'b0;
            r_state   <= StReq;
          end
        end
        StDrain: begin
          if (flush) begin
            r_pend_pc <= new_pc;
            r_br_pend <= 1'b0;
          end
          // The outstanding bus cycle must finish before redirecting.
          if (ibus_ack_i) begin
            r_pc    <= flush ? new_pc : r_pend_pc;
            r_state <= StReq;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    ibus_req_o  = 1'b0;
    ibus_addr_o = 32'h0;
    if_pc       = r_pc;
    if_inst     = 32'h0;
    if_valid    = 1'b0;
    stallreq_o  = 1'b0;
    unique case (r_state)
      StIdle: ;
      StReq: begin
        if (w_misalign) begin
          if_valid = 1'b1;
        end else begin
          ibus_req_o  = 1'b1;
          ibus_addr_o = r_pc;
          stallreq_o  = ~ibus_ack_i;
          if (ibus_ack_i) begin
            if_inst  = ibus_rdata_i;
            if_valid = 1'b1;
          end
        end
      end
      StHold: begin
        if_pc    = r_bufpc;
        if_inst  = r_buf;
        if_valid = 1'b1;
      end
      StDrain: begin
        ibus_req_o  = 1'b1;
        ibus_addr_o = r_pc;
        stallreq_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign inst_adel_o = w_misalign | ((r_state == StHold) & r_adel);

endmodule
